// File: rtl/mem_byte_loader.sv
// Boot loader: packs a length-prefixed byte stream into little-endian words and writes them
// sequentially from BASE_ADDR. Define LOADER_VERIFY_EN to add a readback check cycle per word.
module mem_byte_loader #(
  parameter int                    BYTE_SIZE  = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    WE,
  output logic [ADDR_WIDTH-1:0]   ADDR,
  output logic [8*BYTE_SIZE-1:0]  WD,
  input  logic [8*BYTE_SIZE-1:0]  RD,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              dbg_state
);

  localparam int BC_W = (BYTE_SIZE > 2) ? $clog2(BYTE_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
`ifdef LOADER_VERIFY_EN
    , S_VERIFY = 3'd5
`endif
  } state_t;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready depends on state only.
  state_t                   state, state_nxt;
  logic [BC_W-1:0]          byte_cnt;
  logic [LEN_WIDTH-1:0]     word_cnt, n_words;
  logic [7:0]               len_lo;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [8*BYTE_SIZE-1:0]   wd_q;
  logic                     xfer, last_byte, last_word, len_zero;

  assign xfer      = in_valid && in_ready;
  assign last_byte = (byte_cnt == BC_W'(BYTE_SIZE - 1));
  assign last_word = ((word_cnt + LEN_WIDTH'(1)) == n_words);
  assign len_zero  = (LEN_WIDTH'({in_data, len_lo}) == '0);
  assign ADDR      = addr_q;
  assign WD        = wd_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LEN;
      S_LEN:          if (xfer && byte_cnt[0]) state_nxt = len_zero ? S_DONE : S_DATA;
      S_DATA:         if (xfer && last_byte) state_nxt = S_WRITE;
`ifdef LOADER_VERIFY_EN
      S_WRITE:        state_nxt = S_VERIFY;
      S_VERIFY:       state_nxt = last_word ? S_DONE : S_DATA;
`else
      S_WRITE:        state_nxt = last_word ? S_DONE : S_DATA;
`endif
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    WE       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_LEN, S_DATA: begin in_ready = 1'b1; busy = 1'b1; end
      S_WRITE:       begin WE = 1'b1; busy = 1'b1; end
`ifdef LOADER_VERIFY_EN
      S_VERIFY:      busy = 1'b1;
`endif
      S_DONE:        done = 1'b1;
      default:       ;
    endcase
  end

  // Datapath; the word counter and address advance in the last cycle spent on a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      n_words  <= '0;
      len_lo   <= '0;
      addr_q   <= BASE_ADDR;
      wd_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start) begin
          byte_cnt <= '0;
          word_cnt <= '0;
          addr_q   <= BASE_ADDR;
        end
        S_LEN: if (xfer) begin
          if (!byte_cnt[0]) begin
            len_lo   <= in_data;
            byte_cnt <= BC_W'(1);
          end else begin
            n_words  <= LEN_WIDTH'({in_data, len_lo});
            byte_cnt <= '0;
          end
        end
        S_DATA: if (xfer) begin
          wd_q[{byte_cnt, 3'b000} +: 8] <= in_data;
          byte_cnt <= last_byte ? '0 : byte_cnt + BC_W'(1);
        end
`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
`else
        S_WRITE: begin
`endif
          word_cnt <= word_cnt + LEN_WIDTH'(1);
          if (!last_word) addr_q <= addr_q + ADDR_WIDTH'(BYTE_SIZE);
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_VERIFY_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          err_q <= 1'b0;
    else if ((state == S_IDLE || state == S_DONE) && start) err_q <= 1'b0;
    else if (state == S_VERIFY && RD != wd_q)            err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_rd;
  assign unused_rd = ^RD;
  assign err       = 1'b0;
`endif

endmodule
